// File: rtl/life_pixel_source.sv
// Game-of-Life cell grid held in a bit memory, expanded to pixel blocks and streamed in raster order
// over a valid/ready pixel interface. Define LIFE_GRID_LINES_EN to draw grid lines on dead cells.
module life_pixel_source #(
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          CELL_SHIFT  = 3,
  parameter int          COL_W       = 7,
  parameter int          ROW_W       = 6,
  parameter logic [11:0] ALIVE_COLOR = 12'hFFF,
  parameter logic [11:0] DEAD_COLOR  = 12'h000,
  parameter logic [11:0] GRID_COLOR  = 12'h444
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_col,
  input  logic [ROW_W-1:0] wr_row,
  input  logic             wr_alive,
  output logic             pixel_tvalid,
  input  logic             pixel_tready,
  output logic [11:0]      pixel_tdata,
  output logic             pixel_tuser,
  output logic             pixel_tlast
);

  localparam int COLS   = H_ACTIVE >> CELL_SHIFT;
  localparam int ROWS   = V_ACTIVE >> CELL_SHIFT;
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int X_W    = $clog2(H_ACTIVE);
  localparam int Y_W    = $clog2(V_ACTIVE);

  logic                grid_mem [0:(1<<ADDR_W)-1];
  logic                rd_bit_reg;
  logic [X_W-1:0]      fx_reg;
  logic [Y_W-1:0]      fy_reg;
  logic                inflight_reg;
  logic                sb_first_reg;
  logic                sb_last_reg;
  logic [1:0]          count_reg;
  logic                wr_ptr_reg;
  logic                rd_ptr_reg;

  logic                wr_ok;
  logic                pop;
  logic                push;
  logic                issue;
  logic [2:0]          occupancy;
  logic [COL_W-1:0]    fetch_col;
  logic [ROW_W-1:0]    fetch_row;
  logic [ADDR_W-1:0]   rd_addr;
  logic [11:0]         push_color;
  logic [13:0]         push_word;
  logic [13:0]         head_word;

  assign wr_ok     = reset && wr_en && (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
  assign fetch_col = COL_W'(fx_reg >> CELL_SHIFT);
  assign fetch_row = ROW_W'(fy_reg >> CELL_SHIFT);
  assign rd_addr   = {fetch_row, fetch_col};

  // Occupancy counts the read in flight so a fetch never lands in a full buffer.
  assign pop       = (count_reg != 2'd0) && pixel_tready;
  assign push      = inflight_reg;
  assign occupancy = 3'(count_reg) + 3'(inflight_reg);
  assign issue     = reset && ((occupancy - 3'(pop)) <= 3'd1);

  // Grid memory: no reset, read-first on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      grid_mem[{wr_row, wr_col}] <= wr_alive;
    end
    if (issue) begin
      rd_bit_reg <= grid_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fx_reg       <= '0;
      fy_reg       <= '0;
      inflight_reg <= 1'b0;
      sb_first_reg <= 1'b0;
      sb_last_reg  <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        sb_first_reg <= (fx_reg == '0) && (fy_reg == '0);
        sb_last_reg  <= (fx_reg == X_W'(H_ACTIVE - 1));
        if (fx_reg == X_W'(H_ACTIVE - 1)) begin
          fx_reg <= '0;
          fy_reg <= (fy_reg == Y_W'(V_ACTIVE - 1)) ? '0 : fy_reg + 1'b1;
        end else begin
          fx_reg <= fx_reg + 1'b1;
        end
      end
    end
  end

`ifdef LIFE_GRID_LINES_EN
  logic sb_grid_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sb_grid_reg <= 1'b0;
    end else if (issue) begin
      sb_grid_reg <= (fx_reg[CELL_SHIFT-1:0] == '0) || (fy_reg[CELL_SHIFT-1:0] == '0);
    end
  end

  assign push_color = rd_bit_reg ? ALIVE_COLOR : (sb_grid_reg ? GRID_COLOR : DEAD_COLOR);
`else
  assign push_color = rd_bit_reg ? ALIVE_COLOR : DEAD_COLOR;
`endif

  assign push_word = {push_color, sb_first_reg, sb_last_reg};

  // Two-entry skid buffer; entries are cleared on reset so the outputs read zero.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [13:0] ent_reg;
      always_ff @(posedge clk) begin
        if (!reset) begin
          ent_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          ent_reg <= push_word;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_reg + 2'(push) - 2'(pop);
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  assign head_word    = rd_ptr_reg ? g_entry[1].ent_reg : g_entry[0].ent_reg;
  assign pixel_tvalid = (count_reg != 2'd0);
  assign pixel_tdata  = head_word[13:2];
  assign pixel_tuser  = head_word[1];
  assign pixel_tlast  = head_word[0];

endmodule

// File: tb/tb_life_pixel_source.sv
// Directed bench for life_pixel_source on a reduced 40x24 frame (5x3 cells of 8x8 pixels);
// every beat is compared against a raster model of the cell grid.
module tb_life_pixel_source;
  localparam int H = 40;
  localparam int V = 24;
  localparam int FRAME = H * V;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_col;
  logic [1:0]  wr_row;
  logic        wr_alive;
  logic        pixel_tvalid;
  logic        pixel_tready;
  logic [11:0] pixel_tdata;
  logic        pixel_tuser;
  logic        pixel_tlast;

  int checks = 0;
  int errors = 0;
  int mx = 0;
  int my = 0;
  bit model_grid [0:2][0:4];

  life_pixel_source #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CELL_SHIFT(3), .COL_W(3), .ROW_W(2),
    .ALIVE_COLOR(12'hFFF), .DEAD_COLOR(12'h000), .GRID_COLOR(12'h444)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
    .wr_alive(wr_alive), .pixel_tvalid(pixel_tvalid), .pixel_tready(pixel_tready),
    .pixel_tdata(pixel_tdata), .pixel_tuser(pixel_tuser), .pixel_tlast(pixel_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] exp_color(input int x, input int y);
    bit alive;
    alive = model_grid[y >> 3][x >> 3];
`ifdef LIFE_GRID_LINES_EN
    if (!alive && (((x % 8) == 0) || ((y % 8) == 0))) return 12'h444;
`endif
    return alive ? 12'hFFF : 12'h000;
  endfunction

  task automatic wr(input int col, input int row, input bit alive);
    wr_col   = 3'(col);
    wr_row   = 2'(row);
    wr_alive = alive;
    wr_en    = 1'b1;
    tick();
    wr_en    = 1'b0;
    $display("write col=%0d row=%0d alive=%0d reset=%0d", col, row, alive, reset);
  endtask

  // Consume n beats, comparing each against the model; rnd selects a 50% tready pattern.
  task automatic run_beats(input int n, input bit rnd);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 0;
    logic [13:0] held = '0;
    while (got < n && cyc < 20 * n + 100) begin
      if (stalled) begin
        check("hold_valid", 32'(pixel_tvalid), 32'd1);
        check("hold_data", 32'({pixel_tdata, pixel_tuser, pixel_tlast}), 32'(held));
      end
      pixel_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rnd && got > 0) check("no_bubble", 32'(pixel_tvalid), 32'd1);
      if (pixel_tvalid && pixel_tready) begin
        check($sformatf("tdata(%0d,%0d)", mx, my), 32'(pixel_tdata), 32'(exp_color(mx, my)));
        check($sformatf("tuser(%0d,%0d)", mx, my), 32'(pixel_tuser), 32'(mx == 0 && my == 0));
        check($sformatf("tlast(%0d,%0d)", mx, my), 32'(pixel_tlast), 32'(mx == H - 1));
        if (mx == H - 1) begin
          mx = 0;
          my = (my == V - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
        got++;
        stalled = 0;
      end else begin
        stalled = pixel_tvalid;
        held = {pixel_tdata, pixel_tuser, pixel_tlast};
      end
      tick();
      cyc++;
    end
    if (got < n) check("beat_timeout", 32'(got), 32'(n));
    $display("beats done n=%0d random=%0d next=(%0d,%0d)", got, rnd, mx, my);
  endtask

  task automatic reset_check_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(pixel_tvalid), 32'd0);
    check({tag, "_tdata"}, 32'(pixel_tdata), 32'd0);
    check({tag, "_tuser"}, 32'(pixel_tuser), 32'd0);
    check({tag, "_tlast"}, 32'(pixel_tlast), 32'd0);
  endtask

  task automatic release_and_check_latency();
    reset = 1'b1;
    pixel_tready = 1'b1;
    mx = 0;
    my = 0;
    tick();
    check("latency_edge1_tvalid", 32'(pixel_tvalid), 32'd0);
    tick();
    check("latency_edge2_tvalid", 32'(pixel_tvalid), 32'd1);
    check("first_tuser", 32'(pixel_tuser), 32'd1);
    check("first_tlast", 32'(pixel_tlast), 32'd0);
  endtask

  initial begin
    int togo;
    reset = 1'b0;
    wr_en = 1'b0;
    wr_col = '0;
    wr_row = '0;
    wr_alive = 1'b0;
    pixel_tready = 1'b0;
    repeat (4) tick();
    reset_check_outputs("por");

    // Establish known grid contents, then the legitimate and out-of-range writes.
    reset = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) begin
        wr(c, r, 1'b0);
        model_grid[r][c] = 1'b0;
      end
    wr(0, 0, 1'b1); model_grid[0][0] = 1'b1;
    wr(4, 2, 1'b1); model_grid[2][4] = 1'b1;
    wr(5, 0, 1'b1);
    wr(0, 3, 1'b1);

    // A write made while reset is held must not land.
    reset = 1'b0;
    wr(2, 1, 1'b1);
    reset_check_outputs("rst");
    repeat (3) tick();
    check("rst_hold_tvalid", 32'(pixel_tvalid), 32'd0);

    release_and_check_latency();
    run_beats(FRAME + 1, 1'b0);
    run_beats(2 * FRAME, 1'b1);

    // Stream up to pixel (20,12), then pulse reset mid-frame.
    togo = (12 * H + 20) - (my * H + mx);
    if (togo < 0) togo += FRAME;
    run_beats(togo, 1'b0);
    check("mid_x", 32'(mx), 32'd20);
    check("mid_y", 32'(my), 32'd12);
    reset = 1'b0;
    tick();
    reset_check_outputs("mid_rst");
    repeat (2) tick();
    check("mid_rst_hold_tvalid", 32'(pixel_tvalid), 32'd0);
    release_and_check_latency();
    run_beats(FRAME, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
